road_scheduler: RTL and testbench

Round-robin phase controller that forms the consumer end of the sensor averaging interface. It drives next_road to the per-direction sensors and reads back their 8-bit running averages. Each road's green time is sized from that road's average vehicle count. It sequences GREEN -> YELLOW -> CLEAR per road and drives the one-hot lamp outputs.

---
 rtl/road_scheduler.sv | 133 +++++++++++++
 tb/tb_road_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/road_scheduler.sv
// Round-robin traffic phase controller: CLEAR -> GREEN -> YELLOW per road, green time sized from sensor averages.
// Optional build macro SKIP_EMPTY_EN skips roads whose average is zero (unless every road reads zero).
module road_scheduler #(
  parameter int GREEN_SCALE = 2,
  parameter int MIN_GREEN   = 10,
  parameter int MAX_GREEN   = 200,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int TIMER_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] avg_north,
  input  logic [7:0] avg_east,
  input  logic [7:0] avg_south,
  input  logic [7:0] avg_west,
  output logic [1:0] next_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [1:0] phase,
  output logic       phase_done
);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  localparam int SCALE_W = $clog2(GREEN_SCALE + 1);
  localparam int PROD_W  = 8 + SCALE_W;
  localparam int CMP_W   = (PROD_W > TIMER_W) ? PROD_W : TIMER_W;

  localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  // Product is formed at full width so large averages clamp to MAX_GREEN instead of wrapping.
  function automatic logic [TIMER_W-1:0] green_len(input logic [7:0] avg);
    logic [CMP_W-1:0] prod;
    prod = CMP_W'(avg) * CMP_W'(GREEN_SCALE);
    if (prod < CMP_W'(MIN_GREEN))
      return TIMER_W'(MIN_GREEN);
    else if (prod > CMP_W'(MAX_GREEN))
      return TIMER_W'(MAX_GREEN);
    else
      return TIMER_W'(prod);
  endfunction

  state_t             state, state_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [1:0]         road_d;
  logic [7:0]         avg_sel;

  always_comb begin
    avg_sel = avg_north;
    case (next_road)
      2'd0:    avg_sel = avg_north;
      2'd1:    avg_sel = avg_east;
      2'd2:    avg_sel = avg_south;
      default: avg_sel = avg_west;
    endcase
  end

`ifdef SKIP_EMPTY_EN
  logic all_zero;
  assign all_zero = ~|{avg_north, avg_east, avg_south, avg_west};
`endif

  always_comb begin
    state_d = state;
    timer_d = timer - TIMER_ONE;
    road_d  = next_road;
    case (state)
      CLEAR: begin
        if (timer == '0) begin
`ifdef SKIP_EMPTY_EN
          // An empty road is passed over with another clearance interval; all-empty still serves.
          if (avg_sel == 8'd0 && !all_zero) begin
            road_d  = next_road + 2'd1;
            timer_d = ALLRED_LOAD;
          end else begin
            state_d = GREEN;
            timer_d = green_len(avg_sel) - TIMER_ONE;
          end
`else
          state_d = GREEN;
          timer_d = green_len(avg_sel) - TIMER_ONE;
`endif
        end
      end
      GREEN: begin
        if (timer == '0) begin
          state_d = YELLOW;
          timer_d = YELLOW_LOAD;
        end
      end
      YELLOW: begin
        if (timer == '0) begin
          state_d = CLEAR;
          timer_d = ALLRED_LOAD;
          road_d  = next_road + 2'd1;
        end
      end
      default: begin
        state_d = CLEAR;
        timer_d = ALLRED_LOAD;
      end
    endcase
  end

  // Lamps and status are registered from next-state values so they switch with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      timer      <= ALLRED_LOAD;
      next_road  <= 2'd0;
      green      <= 4'd0;
      yellow     <= 4'd0;
      phase      <= 2'd0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      next_road  <= road_d;
      green      <= (state_d == GREEN)  ? (4'b0001 << road_d) : 4'd0;
      yellow     <= (state_d == YELLOW) ? (4'b0001 << road_d) : 4'd0;
      phase      <= state_d;
      phase_done <= (state_d == YELLOW) && (timer_d == '0);
    end
  end

endmodule

// File: tb/tb_road_scheduler.sv
// Bench for road_scheduler: per-road visits expanded into expected per-cycle lamp records and compared each cycle.
module tb_road_scheduler;
  localparam int GREEN_SCALE = 2;
  localparam int MIN_GREEN   = 10;
  localparam int MAX_GREEN   = 200;
  localparam int YELLOW_TIME = 3;
  localparam int ALLRED_TIME = 2;
  localparam int TIMER_W     = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] av [4];
  logic [1:0] next_road;
  logic [3:0] green, yellow;
  logic [1:0] phase;
  logic       phase_done;

  always #5 clk = ~clk;

  road_scheduler #(
    .GREEN_SCALE(GREEN_SCALE), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_TIME(YELLOW_TIME), .ALLRED_TIME(ALLRED_TIME), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .reset(reset),
    .avg_north(av[0]), .avg_east(av[1]), .avg_south(av[2]), .avg_west(av[3]),
    .next_road(next_road), .green(green), .yellow(yellow),
    .phase(phase), .phase_done(phase_done)
  );

  typedef struct packed {
    logic [1:0] ph;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] rd;
    logic       dn;
  } rec_t;

  rec_t q[$];
  int   mr;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int green_cycles(input int a);
    int g;
    g = a * GREEN_SCALE;
    if (g < MIN_GREEN) g = MIN_GREEN;
    if (g > MAX_GREEN) g = MAX_GREEN;
    return g;
  endfunction

  // One visit of road mr: clearance, then green and yellow unless the road is skipped.
  task automatic plan_visit();
    rec_t r;
    bit   skip;
    int   gc;
    skip = 1'b0;
`ifdef SKIP_EMPTY_EN
    skip = (av[mr] == 8'd0) && ((int'(av[0]) + int'(av[1]) + int'(av[2]) + int'(av[3])) != 0);
`endif
    for (int i = 0; i < ALLRED_TIME; i++) begin
      r = '{ph: 2'd0, g: 4'd0, y: 4'd0, rd: 2'(mr), dn: 1'b0};
      q.push_back(r);
    end
    if (!skip) begin
      gc = green_cycles(int'(av[mr]));
      for (int i = 0; i < gc; i++) begin
        r = '{ph: 2'd1, g: 4'(1 << mr), y: 4'd0, rd: 2'(mr), dn: 1'b0};
        q.push_back(r);
      end
      for (int i = 0; i < YELLOW_TIME; i++) begin
        r = '{ph: 2'd2, g: 4'd0, y: 4'(1 << mr), rd: 2'(mr), dn: (i == YELLOW_TIME - 1)};
        q.push_back(r);
      end
    end
    mr = (mr + 1) % 4;
  endtask

  task automatic do_visit(input int chg_at, input logic [7:0] chg_n, input bit stop_y);
    rec_t e;
    int   n;
    n = 0;
    plan_visit();
    while (q.size() > 0) begin
      e = q.pop_front();
      check("phase",      32'(phase),      32'(e.ph));
      check("green",      32'(green),      32'(e.g));
      check("yellow",     32'(yellow),     32'(e.y));
      check("next_road",  32'(next_road),  32'(e.rd));
      check("phase_done", 32'(phase_done), 32'(e.dn));
      if (stop_y && e.ph == 2'd2) begin
        q.delete();
        return;
      end
      if (n == chg_at) av[0] = chg_n;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_av(input logic [7:0] n, input logic [7:0] e, input logic [7:0] s, input logic [7:0] w);
    av[0] = n; av[1] = e; av[2] = s; av[3] = w;
  endtask

  task automatic check_reset_state();
    check("rst_phase",      32'(phase),      32'd0);
    check("rst_green",      32'(green),      32'd0);
    check("rst_yellow",     32'(yellow),     32'd0);
    check("rst_next_road",  32'(next_road),  32'd0);
    check("rst_phase_done", 32'(phase_done), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_av(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    mr = 0;

    set_av(8'd20, 8'd20, 8'd20, 8'd20);
    repeat (4) do_visit(-1, 8'd0, 1'b0);

    set_av(8'd0, 8'd255, 8'd20, 8'd20);
    repeat (4) do_visit(-1, 8'd0, 1'b0);

    set_av(8'd5, 8'd50, 8'd100, 8'd7);
    repeat (4) do_visit(-1, 8'd0, 1'b0);

    // North average rises mid-green; the running green keeps its latched length.
    set_av(8'd20, 8'd20, 8'd20, 8'd20);
    do_visit(20, 8'd80, 1'b0);
    repeat (3) do_visit(-1, 8'd0, 1'b0);
    do_visit(-1, 8'd0, 1'b0);

    set_av(8'd20, 8'd0, 8'd20, 8'd20);
    repeat (4) do_visit(-1, 8'd0, 1'b0);

    set_av(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (4) do_visit(-1, 8'd0, 1'b0);

    repeat (8) begin
      for (int i = 0; i < 4; i++)
        av[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      do_visit(-1, 8'd0, 1'b0);
    end

    // Reset arriving during the south yellow returns to a fresh north clearance.
    set_av(8'd20, 8'd20, 8'd20, 8'd20);
    while (mr != 2) do_visit(-1, 8'd0, 1'b0);
    do_visit(-1, 8'd0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    mr = 0;
    repeat (2) do_visit(-1, 8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
